// File: rtl/fft_peak_detector.sv
// fft_peak_detector
//
// Streaming peak-bin detector for one FFT frame of N_SAMPLES signed words.
// The block tracks the bin with the largest absolute value, then emits one
// packed result word per frame: {flag, best_idx, saturated best_mag}.
// The flag is set when the frame peak is strictly above a programmable
// threshold.
//
// Ports
//   clk         single clock; all state changes on its rising edge
//   reset       asynchronous, active-low reset
//   recv_msg    signed FFT bin sample, bin 0 first
//   recv_val    sample valid
//   recv_rdy    block can accept a sample (ACCUM state, out of reset)
//   thresh_msg  unsigned magnitude threshold
//   thresh_val  threshold write strobe
//   thresh_rdy  high whenever out of reset
//   send_msg    packed result word, held stable while send_val is high
//   send_val    result valid (SEND state)
//   send_rdy    consumer accepts the result
module fft_peak_detector #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [BIT_WIDTH-1:0] recv_msg,
  input  logic                        recv_val,
  output logic                        recv_rdy,
  input  logic        [BIT_WIDTH-1:0] thresh_msg,
  input  logic                        thresh_val,
  output logic                        thresh_rdy,
  output logic        [BIT_WIDTH-1:0] send_msg,
  output logic                        send_val,
  input  logic                        send_rdy
);

  localparam int IDX_W = $clog2(N_SAMPLES);
  // Width of the magnitude field in the packed result word.
  localparam int MAG_W = BIT_WIDTH - 1 - IDX_W;

  // Elaboration-time guard on the parameter set. DECIMAL_PT does not affect
  // the arithmetic (magnitude ordering is scale-free) but must still lie
  // inside the word.
  if ((N_SAMPLES < 2) || ((N_SAMPLES & (N_SAMPLES - 1)) != 0) ||
      (DECIMAL_PT < 0) || (DECIMAL_PT >= BIT_WIDTH) || (MAG_W < 1)) begin : g_param_check
    $error("fft_peak_detector: unsupported parameter combination");
  end

  typedef enum logic {
    ACCUM = 1'b0,
    SEND  = 1'b1
  } state_t;

  // Absolute value with the most negative input clamped to the largest
  // positive value, so the result always fits an unsigned BIT_WIDTH word
  // with the top bit clear.
  function automatic logic [BIT_WIDTH-1:0] abs_sat(input logic signed [BIT_WIDTH-1:0] x);
    logic signed [BIT_WIDTH-1:0] most_neg;
    logic signed [BIT_WIDTH-1:0] neg_x;
    most_neg = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    neg_x    = -x;
    if (x == most_neg) begin
      abs_sat = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    end else if (x < 0) begin
      abs_sat = $unsigned(neg_x);
    end else begin
      abs_sat = $unsigned(x);
    end
  endfunction

  // Clamp a magnitude into the MAG_W-bit result field.
  function automatic logic [MAG_W-1:0] sat_field(input logic [BIT_WIDTH-1:0] m);
    if (|m[BIT_WIDTH-1:MAG_W]) begin
      sat_field = {MAG_W{1'b1}};
    end else begin
      sat_field = m[MAG_W-1:0];
    end
  endfunction

  state_t               state;
  logic [IDX_W-1:0]     cnt;
  logic [BIT_WIDTH-1:0] thr_reg;
  logic [BIT_WIDTH-1:0] best_mag_p1;
  logic [IDX_W-1:0]     best_idx_p1;
  logic [BIT_WIDTH-1:0] result_p1;

  logic signed [BIT_WIDTH-1:0] sample_p0;
  logic [BIT_WIDTH-1:0]        mag_p0;
  logic                        vld_p0;
  logic                        last_p0;
  logic                        take_p0;
  logic [BIT_WIDTH-1:0]        nxt_mag_p0;
  logic [IDX_W-1:0]            nxt_idx_p0;
  logic                        nxt_flag_p0;

  // Handshake outputs decode the state register only; the reset term keeps
  // both ready signals low while reset is asserted.
  assign recv_rdy   = reset && (state == ACCUM);
  assign thresh_rdy = reset;
  assign send_val   = (state == SEND);
  assign send_msg   = result_p1;

  // ---- stage p0: magnitude of the incoming sample and running-max compare
  assign sample_p0 = recv_msg;
  assign mag_p0    = abs_sat(sample_p0);
  assign vld_p0    = recv_val && recv_rdy;
  assign last_p0   = (cnt == IDX_W'(N_SAMPLES - 1));
  // Bin 0 always loads; later bins replace only on a strictly larger value,
  // so equal peaks keep the lowest index.
  assign take_p0     = (cnt == '0) || (mag_p0 > best_mag_p1);
  assign nxt_mag_p0  = take_p0 ? mag_p0 : best_mag_p1;
  assign nxt_idx_p0  = take_p0 ? cnt : best_idx_p1;
  // Compared against the threshold as it stood before this edge; a write in
  // the same cycle lands in thr_reg on this edge and only affects later frames.
  assign nxt_flag_p0 = (nxt_mag_p0 > thr_reg);

  // ---- stage p1: accumulator, result word and frame FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ACCUM;
      cnt         <= '0;
      thr_reg     <= '0;
      best_mag_p1 <= '0;
      best_idx_p1 <= '0;
      result_p1   <= '0;
    end else begin
      if (thresh_val) begin
        thr_reg <= thresh_msg;
      end

      case (state)
        ACCUM: begin
          if (vld_p0) begin
            best_mag_p1 <= nxt_mag_p0;
            best_idx_p1 <= nxt_idx_p0;
            if (last_p0) begin
              cnt       <= '0;
              result_p1 <= {nxt_flag_p0, nxt_idx_p0, sat_field(nxt_mag_p0)};
              state     <= SEND;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        SEND: begin
          // Result word is held until the consumer takes it; no samples are
          // accepted meanwhile, so frames never overlap.
          if (send_rdy) begin
            state <= ACCUM;
          end
        end

        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed bench for fft_peak_detector (BIT_WIDTH=32, N_SAMPLES=8).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_fft_peak_detector;

  logic        clk;
  logic        reset;
  logic [31:0] recv_msg;
  logic        recv_val;
  logic        recv_rdy;
  logic [31:0] thresh_msg;
  logic        thresh_val;
  logic        thresh_rdy;
  logic [31:0] send_msg;
  logic        send_val;
  logic        send_rdy;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] frm [8];

  fft_peak_detector #(
    .BIT_WIDTH (32),
    .DECIMAL_PT(16),
    .N_SAMPLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .recv_msg  (recv_msg),
    .recv_val  (recv_val),
    .recv_rdy  (recv_rdy),
    .thresh_msg(thresh_msg),
    .thresh_val(thresh_val),
    .thresh_rdy(thresh_rdy),
    .send_msg  (send_msg),
    .send_val  (send_val),
    .send_rdy  (send_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_thr(input logic [31:0] v);
    thresh_val = 1'b1;
    thresh_msg = v;
    step();
    thresh_val = 1'b0;
  endtask

  // Feeds frm[0..7]. Optional idle gap before bin 4 (with a large value on
  // the bus that must be ignored) and optional threshold write on the edge
  // that accepts the last bin.
  task automatic feed_frame(input string tag, input bit gap,
                            input bit thr_last, input logic [31:0] thr_v);
    for (int i = 0; i < 8; i++) begin
      if (gap && i == 4) begin
        recv_val = 1'b0;
        recv_msg = 32'h7FFF_FFFF;
        step();
      end
      recv_val = 1'b1;
      recv_msg = frm[i];
      if (thr_last && i == 7) begin
        thresh_val = 1'b1;
        thresh_msg = thr_v;
      end
      if (i == 0) check({tag, ".recv_rdy_first"}, recv_rdy, 32'd1);
      if (i == 7) begin
        check({tag, ".recv_rdy_last"}, recv_rdy, 32'd1);
        check({tag, ".send_val_before_last"}, send_val, 32'd0);
      end
      step();
    end
    recv_val   = 1'b0;
    thresh_val = 1'b0;
    check({tag, ".send_val_after_last"}, send_val, 32'd1);
    check({tag, ".recv_rdy_in_send"}, recv_rdy, 32'd0);
  endtask

  task automatic take_result(input string tag, input logic [31:0] exp);
    check({tag, ".send_msg"}, send_msg, exp);
    send_rdy = 1'b1;
    step();
    send_rdy = 1'b0;
    check({tag, ".send_val_after_take"}, send_val, 32'd0);
    check({tag, ".recv_rdy_after_take"}, recv_rdy, 32'd1);
  endtask

  initial begin
    reset      = 1'b0;
    recv_msg   = '0;
    recv_val   = 1'b0;
    thresh_msg = '0;
    thresh_val = 1'b0;
    send_rdy   = 1'b0;

    // Reset state
    step();
    step();
    check("rst.send_val", send_val, 32'd0);
    check("rst.send_msg", send_msg, 32'd0);
    check("rst.recv_rdy", recv_rdy, 32'd0);
    check("rst.thresh_rdy", thresh_rdy, 32'd0);
    reset = 1'b1;
    #1;
    check("rel.recv_rdy", recv_rdy, 32'd1);
    check("rel.thresh_rdy", thresh_rdy, 32'd1);
    check("rel.send_val", send_val, 32'd0);
    step();

    // Basic frame, threshold 0 from reset
    frm = '{32'd1, 32'd5, 32'hFFFF_FFF7, 32'd3, 32'd0, 32'd2, 32'd7, 32'd4};
    feed_frame("basic", 1'b0, 1'b0, 32'd0);
    take_result("basic", 32'hA000_0009);

    // Ties and threshold equality (with an input gap)
    write_thr(32'd9);
    frm = '{32'd9, 32'hFFFF_FFF7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd9};
    feed_frame("tie_thr9", 1'b1, 1'b0, 32'd0);
    take_result("tie_thr9", 32'h0000_0009);
    write_thr(32'd8);
    feed_frame("tie_thr8", 1'b0, 1'b0, 32'd0);
    take_result("tie_thr8", 32'h8000_0009);

    // Most negative input saturates
    frm = '{32'd0, 32'd0, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0};
    feed_frame("sat", 1'b0, 1'b0, 32'd0);
    take_result("sat", 32'hBFFF_FFFF);

    // Back-pressure: result held, stray samples refused
    frm = '{32'd3, 32'hFFFF_FFEC, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    feed_frame("bp", 1'b0, 1'b0, 32'd0);
    recv_val = 1'b1;
    recv_msg = 32'd1000;
    for (int c = 0; c < 5; c++) begin
      check("bp.hold_val", send_val, 32'd1);
      check("bp.hold_msg", send_msg, 32'h9000_0014);
      check("bp.hold_rdy", recv_rdy, 32'd0);
      step();
    end
    recv_val = 1'b0;
    take_result("bp", 32'h9000_0014);
    frm = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFF9, 32'd2};
    feed_frame("b2b1", 1'b0, 1'b0, 32'd0);
    take_result("b2b1", 32'h6000_0007);
    frm = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC,
            32'd4, 32'd3, 32'd2, 32'd1};
    feed_frame("b2b2", 1'b0, 1'b0, 32'd0);
    take_result("b2b2", 32'h3000_0004);

    // Threshold written on the last-sample edge only affects later frames
    write_thr(32'd10);
    frm = '{32'd20, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    feed_frame("thr_same", 1'b0, 1'b1, 32'd50);
    take_result("thr_same", 32'h8000_0014);
    feed_frame("thr_next", 1'b0, 1'b0, 32'd0);
    take_result("thr_next", 32'h0000_0014);

    // Reset mid-frame discards the partial frame and the threshold
    recv_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      recv_msg = (i == 0) ? 32'd100 : 32'(i);
      step();
    end
    recv_val = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst.send_val", send_val, 32'd0);
    check("mid_rst.recv_rdy", recv_rdy, 32'd0);
    check("mid_rst.thresh_rdy", thresh_rdy, 32'd0);
    step();
    reset = 1'b1;
    #1;
    check("mid_rst.rel_rdy", recv_rdy, 32'd1);
    step();
    frm = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    feed_frame("post_rst", 1'b0, 1'b0, 32'd0);
    take_result("post_rst", 32'hF000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
